// File: rtl/fetch_unit.sv
// Instruction fetch unit: a single outstanding instruction-memory request,
// one held instruction for decode, and redirect handling for branches/jumps
// resolved in the execute stage (flush, link and misalignment pulses).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        ex_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_src,
  input  logic        jump_dst,
  input  logic [1:0]  branch_type,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_target,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        flush,
  output logic        link_valid,
  output logic [31:0] link_addr,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;          // target remembered while draining a stale request
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        flush_q, flush_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        misalign_q, misalign_d;

  logic        cond;
  logic        redirect;
  logic [31:0] ex_pc_plus4;
  logic [31:0] target;

  // Branch condition, redirect decision and redirect target from execute-stage inputs
  always_comb begin
    cond        = 1'b0;
    ex_pc_plus4 = ex_pc + 32'd4;
    case (branch_type)
      2'b00: cond = (rs_val == rt_val);
      2'b01: cond = (rs_val != rt_val);
      2'b10: cond = ($signed(rs_val) <= 32'sd0);
      2'b11: cond = ($signed(rs_val) > 32'sd0);
      default: cond = 1'b0;
    endcase
    redirect = ex_valid & (jump | (branch & cond));
    if (jump) begin
      // Register jumps always use the word-aligned target; misalignment is only reported
      if (jump_src) target = {rs_val[31:2], 2'b00};
      else          target = {ex_pc_plus4[31:28], ex_target, 2'b00};
    end else begin
      target = ex_pc_plus4 + (ex_imm << 2);
    end
  end

  // Next-state and datapath updates; redirect outranks every memory/decode event
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;
    link_valid_d  = 1'b0;
    link_addr_d   = link_addr_q;
    misalign_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d          = target;
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
        end
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
          if (imem_ack) begin
            // Response landed this cycle: drop it and fetch from the target at once
            pc_d    = target;
            state_d = S_FETCH;
          end else begin
            // Request still outstanding: keep its address until it completes
            tgt_d   = target;
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          flush_d       = 1'b1;
          instr_valid_d = 1'b0;
          pc_d          = target;
          state_d       = S_FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect) begin
          flush_d = 1'b1;
          if (imem_ack) begin
            // Stale request finished in the same cycle: no further ack will come
            pc_d    = target;
            state_d = S_FETCH;
          end else begin
            tgt_d = target;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Link and misalignment reporting do not depend on the fetch state
    if (ex_valid && jump && jump_dst) begin
      link_valid_d = 1'b1;
      link_addr_d  = ex_pc_plus4;
    end
    if (ex_valid && jump && jump_src && (rs_val[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      tgt_q         <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      link_valid_q  <= 1'b0;
      link_addr_q   <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
      link_valid_q  <= link_valid_d;
      link_addr_q   <= link_addr_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign flush       = flush_q;
  assign link_valid  = link_valid_q;
  assign link_addr   = link_addr_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of redirect/no-redirect vectors each
// issued while a fetch is pending, plus hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        ex_valid, branch, jump, jump_src, jump_dst;
  logic [1:0]  branch_type;
  logic [31:0] ex_pc, ex_imm;
  logic [25:0] ex_target;
  logic [31:0] rs_val, rt_val;
  logic        flush, link_valid, misalign;
  logic [31:0] link_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .ex_valid(ex_valid), .branch(branch), .jump(jump), .jump_src(jump_src), .jump_dst(jump_dst),
    .branch_type(branch_type), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_target(ex_target),
    .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .link_valid(link_valid), .link_addr(link_addr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev, br, jp, js, jd;
    logic [1:0]  bt;
    logic [31:0] pc, imm;
    logic [25:0] t26;
    logic [31:0] rs, rt;
    logic        redir;
    logic [31:0] tgt;
    logic        link;
    logic [31:0] laddr;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic ev, input logic br, input logic jp, input logic js,
                              input logic jd, input logic [1:0] bt, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [25:0] t26,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic redir, input logic [31:0] tgt, input logic link,
                              input logic [31:0] laddr, input logic mis);
    vec_t v;
    v.ev = ev; v.br = br; v.jp = jp; v.js = js; v.jd = jd; v.bt = bt;
    v.pc = pc; v.imm = imm; v.t26 = t26; v.rs = rs; v.rt = rt;
    v.redir = redir; v.tgt = tgt; v.link = link; v.laddr = laddr; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_ex();
    ex_valid = 0; branch = 0; jump = 0; jump_src = 0; jump_dst = 0;
    branch_type = 2'b00; ex_pc = 0; ex_imm = 0; ex_target = 0; rs_val = 0; rt_val = 0;
  endtask

  task automatic set_ex(input vec_t v);
    ex_valid = v.ev; branch = v.br; jump = v.jp; jump_src = v.js; jump_dst = v.jd;
    branch_type = v.bt; ex_pc = v.pc; ex_imm = v.imm; ex_target = v.t26;
    rs_val = v.rs; rt_val = v.rt;
  endtask

  // Register jump helper used by the hand-written sequences
  task automatic set_jr(input logic [31:0] rs);
    clr_ex();
    ex_valid = 1; jump = 1; jump_src = 1; rs_val = rs;
  endtask

  // Leaves the DUT in IDLE with reset released
  task automatic do_reset();
    rst = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0; clr_ex();
    cyc();
    rst = 0;
  endtask

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0; clr_ex();
    @(negedge clk);

    //         ev br jp js jd bt     ex_pc          imm            t26           rs             rt          redir tgt            link laddr         mis
    vecs[0]  = mk(1, 1, 0, 0, 0, 2'b00, 32'h0000_0100, 32'hFFFF_FFFE, 26'h0,       32'd7,         32'd7,       1, 32'h0000_00FC, 0, 32'h0,        0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 2'b00, 32'h0000_0100, 32'hFFFF_FFFE, 26'h0,       32'd7,         32'd8,       0, 32'h0,         0, 32'h0,        0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 2'b01, 32'h0000_0200, 32'd4,         26'h0,       32'd7,         32'd8,       1, 32'h0000_0214, 0, 32'h0,        0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 2'b01, 32'h0000_0200, 32'd4,         26'h0,       32'd5,         32'd5,       0, 32'h0,         0, 32'h0,        0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 2'b11, 32'h0000_0300, 32'd1,         26'h0,       32'h8000_0000, 32'd0,       0, 32'h0,         0, 32'h0,        0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 2'b10, 32'h0000_0300, 32'd1,         26'h0,       32'h8000_0000, 32'd0,       1, 32'h0000_0308, 0, 32'h0,        0);
    vecs[6]  = mk(1, 1, 0, 0, 0, 2'b10, 32'h0000_0010, 32'd0,         26'h0,       32'd0,         32'd0,       1, 32'h0000_0014, 0, 32'h0,        0);
    vecs[7]  = mk(1, 1, 0, 0, 0, 2'b11, 32'h0000_0020, 32'hFFFF_FFFF, 26'h0,       32'd1,         32'd0,       1, 32'h0000_0020, 0, 32'h0,        0);
    vecs[8]  = mk(1, 0, 1, 0, 0, 2'b00, 32'hF000_0000, 32'd0,         26'h40,      32'd0,         32'd0,       1, 32'hF000_0100, 0, 32'h0,        0);
    vecs[9]  = mk(1, 0, 1, 1, 1, 2'b00, 32'h0000_0040, 32'd0,         26'h0,       32'h0000_0203, 32'd0,       1, 32'h0000_0200, 1, 32'h0000_0044, 1);
    vecs[10] = mk(1, 0, 1, 0, 1, 2'b00, 32'h0000_1000, 32'd0,         26'h3FFFFFF, 32'd0,         32'd0,       1, 32'h0FFF_FFFC, 1, 32'h0000_1004, 0);
    vecs[11] = mk(1, 1, 1, 1, 0, 2'b00, 32'h0000_0000, 32'h10,        26'h0,       32'h0000_0080, 32'h80,      1, 32'h0000_0080, 0, 32'h0,        0);
    vecs[12] = mk(0, 0, 1, 1, 1, 2'b00, 32'h0000_0040, 32'd0,         26'h0,       32'h0000_0003, 32'd0,       0, 32'h0,         0, 32'h0,        0);
    vecs[13] = mk(1, 1, 0, 0, 0, 2'b01, 32'hFFFF_FFF8, 32'd1,         26'h0,       32'd1,         32'd0,       1, 32'h0000_0000, 0, 32'h0,        0);

    // Each vector is applied while the first fetch after reset is still pending
    for (int i = 0; i < 14; i++) begin
      do_reset();
      cyc();                                   // IDLE -> FETCH at 0
      chk($sformatf("v%0d req_fetch", i), 32'(imem_req), 32'd1);
      set_ex(vecs[i]);
      cyc();
      clr_ex();
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].redir));
      chk($sformatf("v%0d link_valid", i), 32'(link_valid), 32'(vecs[i].link));
      chk($sformatf("v%0d link_addr", i), link_addr, vecs[i].laddr);
      chk($sformatf("v%0d misalign", i), 32'(misalign), 32'(vecs[i].mis));
      chk($sformatf("v%0d addr_held", i), imem_addr, 32'h0);
      chk($sformatf("v%0d req_held", i), 32'(imem_req), 32'd1);
      if (vecs[i].redir) begin
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;      // stale response, must be dropped
        cyc();
        chk($sformatf("v%0d flush_end", i), 32'(flush), 32'd0);
        chk($sformatf("v%0d tgt_addr", i), imem_addr, vecs[i].tgt);
        chk($sformatf("v%0d valid_after_drop", i), 32'(instr_valid), 32'd0);
      end
      imem_ack = 1; imem_rdata = 32'hA500_0000 + 32'(i);
      cyc();
      imem_ack = 0;
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'd1);
      chk($sformatf("v%0d instr", i), instr, 32'hA500_0000 + 32'(i));
      chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].redir ? vecs[i].tgt : 32'h0);
      $display("vector %0d applied (redirect=%0d target=%h)", i, vecs[i].redir, vecs[i].tgt);
    end

    // Reset values, first fetch and long hold
    do_reset();
    chk("rst req", 32'(imem_req), 32'd0);
    chk("rst addr", imem_addr, 32'h0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst link_valid", 32'(link_valid), 32'd0);
    chk("rst link_addr", link_addr, 32'h0);
    chk("rst misalign", 32'(misalign), 32'd0);
    cyc();
    chk("first req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'h0);
    cyc();
    chk("addr stable", imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'h2008_0005;
    cyc();
    imem_ack = 0; imem_rdata = 32'hFFFF_FFFF;
    chk("first valid", 32'(instr_valid), 32'd1);
    chk("first instr", instr, 32'h2008_0005);
    chk("first instr_pc", instr_pc, 32'h0);
    chk("next addr", imem_addr, 32'h4);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("hold%0d valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("hold%0d instr", k), instr, 32'h2008_0005);
      chk($sformatf("hold%0d req", k), 32'(imem_req), 32'd0);
    end
    instr_ready = 1;
    cyc();
    instr_ready = 0;
    chk("accept valid", 32'(instr_valid), 32'd0);
    chk("accept req", 32'(imem_req), 32'd1);
    chk("accept addr", imem_addr, 32'h4);
    $display("sequence first-fetch/hold done");

    // Redirect in HOLD beats a same-cycle instr_ready
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_ack = 0;
    chk("hold2 valid", 32'(instr_valid), 32'd1);
    instr_ready = 1; set_jr(32'h0000_0500);
    cyc();
    instr_ready = 0; clr_ex();
    chk("holdredir flush", 32'(flush), 32'd1);
    chk("holdredir valid", 32'(instr_valid), 32'd0);
    chk("holdredir addr", imem_addr, 32'h500);
    chk("holdredir req", 32'(imem_req), 32'd1);
    $display("sequence hold-redirect done");

    // Redirect in FETCH with a same-cycle ack: data dropped, fetch target directly
    set_jr(32'h0000_0700); imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    clr_ex(); imem_ack = 0;
    chk("fackredir flush", 32'(flush), 32'd1);
    chk("fackredir valid", 32'(instr_valid), 32'd0);
    chk("fackredir addr", imem_addr, 32'h700);
    chk("fackredir req", 32'(imem_req), 32'd1);
    $display("sequence fetch-ack-redirect done");

    // Second redirect while draining overwrites the stored target
    do_reset();
    cyc();
    set_jr(32'h0000_0800);
    cyc();
    set_jr(32'h0000_0900);
    cyc();
    clr_ex();
    chk("drop2 flush", 32'(flush), 32'd1);
    chk("drop2 req", 32'(imem_req), 32'd1);
    chk("drop2 addr", imem_addr, 32'h0);
    imem_ack = 1;
    cyc();
    imem_ack = 0;
    chk("drop2 tgt", imem_addr, 32'h900);
    chk("drop2 valid", 32'(instr_valid), 32'd0);
    $display("sequence double-redirect done");

    // Redirect while IDLE
    do_reset();
    set_jr(32'h0000_0600);
    cyc();
    clr_ex();
    chk("idleredir flush", 32'(flush), 32'd1);
    chk("idleredir addr", imem_addr, 32'h600);
    chk("idleredir req", 32'(imem_req), 32'd1);
    $display("sequence idle-redirect done");

    // Reset while draining, ack arrives in IDLE and must be ignored
    do_reset();
    cyc();
    set_jr(32'h0000_0A00);
    cyc();
    clr_ex();
    chk("droprst req_before", 32'(imem_req), 32'd1);
    rst = 1;
    cyc();
    rst = 0; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
    chk("droprst idle req", 32'(imem_req), 32'd0);
    chk("droprst idle flush", 32'(flush), 32'd0);
    cyc();
    imem_ack = 0;
    chk("droprst addr", imem_addr, 32'h0);
    chk("droprst valid", 32'(instr_valid), 32'd0);
    chk("droprst flush", 32'(flush), 32'd0);
    chk("droprst req", 32'(imem_req), 32'd1);
    imem_ack = 1; imem_rdata = 32'h1111_1111;
    cyc();
    imem_ack = 0;
    chk("droprst instr", instr, 32'h1111_1111);
    chk("droprst instr_pc", instr_pc, 32'h0);
    $display("sequence reset-in-drop done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
